voltage_text_updater: RTL and testbench

//  Sequences per-channel voltage readings into the writable on-screen text buffer.

---
 rtl/voltage_text_updater_pkg.sv | 43 ++++
 rtl/bin2bcd_seq.sv | 44 ++++
 rtl/voltage_text_updater.sv | 102 ++++++++++
 tb/tb_voltage_text_updater.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voltage_text_updater_pkg.sv
// rtl/voltage_text_updater_pkg.sv - shared constants, state encoding and digit helpers
package voltage_text_updater_pkg;

  localparam int ROW_LEN = 12;
  localparam int DIG_OFS = 6;
  localparam logic [6:0] ASCII_ZERO  = 7'h30;
  localparam logic [6:0] ASCII_SPACE = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Shift-and-add form keeps the default 12-char row free of a multiplier.
  function automatic logic [7:0] row_base(input logic [3:0] ch);
    logic [7:0] c;
    c = {4'b0, ch};
    if (ROW_LEN == 12) return (c << 3) + (c << 2);
    else               return 8'(int'(c) * ROW_LEN);
  endfunction

  function automatic logic [6:0] digit_char(input logic [15:0] bcd, input logic [1:0] k);
    logic [3:0] d;
    case (k)
      2'd0:    d = bcd[15:12];
      2'd1:    d = bcd[11:8];
      2'd2:    d = bcd[7:4];
      default: d = bcd[3:0];
    endcase
    return ASCII_ZERO + {3'b000, d};
  endfunction

  function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic b);
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) a[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else                       a[4*i +: 4] = bcd[4*i +: 4];
    end
    return {a[14:0], b};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 12-bit binary to 4-digit BCD, one double-dabble step per cycle
module bin2bcd_seq
  import voltage_text_updater_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  logic [10:0] sh;
  logic [3:0]  cnt;
  logic        active;

  // The start edge performs the first step, so the 12th step lands 11 cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd    <= '0;
      sh     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd    <= dd_step(16'h0000, bin[11]);
        sh     <= bin[10:0];
        cnt    <= 4'd11;
        active <= 1'b1;
      end else if (active) begin
        bcd <= dd_step(bcd, sh[10]);
        sh  <= {sh[9:0], 1'b0};
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/voltage_text_updater.sv
// rtl/voltage_text_updater.sv - writes per-channel mV readings as 4 ASCII digits into the text RAM
module voltage_text_updater
  import voltage_text_updater_pkg::*;
#(
  parameter int N_CH = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vol_valid,
  input  logic [3:0]  vol_ch,
  input  logic [11:0] vol_mv,
  output logic        vol_ready,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [6:0]  wr_data,
  output logic        busy,
  output logic        ch_err
);

  localparam logic [4:0] N_CH_L = 5'(N_CH);

  state_t      state;
  logic [7:0]  base_q;
  logic [1:0]  dig;
  logic        transfer;
  logic        ch_ok;
  logic        bcd_start;
  logic        bcd_done;
  logic [15:0] bcd;

  assign transfer  = vol_valid && vol_ready;
  assign ch_ok     = {1'b0, vol_ch} < N_CH_L;
  assign bcd_start = transfer && ch_ok;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (vol_mv),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      vol_ready <= 1'b1;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= ASCII_SPACE;
      ch_err    <= 1'b0;
      dig       <= '0;
      base_q    <= '0;
    end else begin
      ch_err <= 1'b0;
      wr_en  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            if (ch_ok) begin
              base_q    <= row_base(vol_ch);
              state     <= ST_CONV;
              vol_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              ch_err <= 1'b1;
            end
          end
        end
        ST_CONV: begin
          if (bcd_done) begin
            state   <= ST_WRITE;
            wr_en   <= 1'b1;
            wr_addr <= base_q + 8'(DIG_OFS);
            wr_data <= digit_char(bcd, 2'd0);
            dig     <= 2'd1;
          end
        end
        ST_WRITE: begin
          // dig wraps to 0 after the units digit; that cycle closes the row.
          if (dig == 2'd0) begin
            state     <= ST_IDLE;
            vol_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= wr_addr + 8'd1;
            wr_data <= digit_char(bcd, dig);
            dig     <= dig + 2'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          vol_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voltage_text_updater.sv
// tb/tb_voltage_text_updater.sv - directed self-checking bench for voltage_text_updater
module tb_voltage_text_updater;

  logic        clk = 1'b0;
  logic        rst;
  logic        vol_valid;
  logic [3:0]  vol_ch;
  logic [11:0] vol_mv;
  logic        vol_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [6:0]  wr_data;
  logic        busy;
  logic        ch_err;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [6:0] ram     [256];
  logic [6:0] exp_ram [256];

  voltage_text_updater dut (
    .clk       (clk),
    .rst       (rst),
    .vol_valid (vol_valid),
    .vol_ch    (vol_ch),
    .vol_mv    (vol_mv),
    .vol_ready (vol_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .ch_err    (ch_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
      wr_count     <= wr_count + 1;
    end
  end

  function automatic logic [6:0] exp_char(input int mv, input int k);
    int d;
    case (k)
      0:       d = mv / 1000;
      1:       d = (mv / 100) % 10;
      2:       d = (mv / 10) % 10;
      default: d = mv % 10;
    endcase
    return 7'(48 + d);
  endfunction

  function automatic logic [6:0] init_char(input int a);
    return 7'(65 + a % 26);
  endfunction

  // Present a sample at a negedge, wait (bounded) for the accepting edge, return at the following negedge.
  task automatic offer(input logic [3:0] ch, input logic [11:0] mv, input bit hold);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    vol_ch    = ch;
    vol_mv    = mv;
    vol_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (vol_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout ch=%0d mv=%0d: vol_ready never seen within 40 cycles", ch, mv);
    end else begin
      @(negedge clk);
    end
    if (!hold) vol_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vol_valid = 1'b0;
    vol_ch = '0;
    vol_mv = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (vol_ready !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || ch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b wr_en=%b busy=%b ch_err=%b, want 1 0 0 0", vol_ready, wr_en, busy, ch_err);
    end
    n_checks++;
    if (wr_addr !== 8'd0 || wr_data !== 7'h20) begin
      n_fail++;
      $display("FAIL reset_port: addr=%0d data=%h, want 0 20", wr_addr, wr_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_conversion();
    logic [3:0]  chs [4] = '{4'd0, 4'd13, 4'd7, 4'd3};
    logic [11:0] mvs [4] = '{12'd89, 12'd4095, 12'd1000, 12'd0};
    int base, wc0, k;
    for (int v = 0; v < 4; v++) begin
      base = int'(chs[v]) * 12 + 6;
      offer(chs[v], mvs[v], 1'b0);
      wc0 = wr_count;
      for (int i = 1; i <= 16; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (i >= 12 && i <= 15) begin
          k = i - 12;
          n_checks++;
          if (wr_en !== 1'b1 || wr_addr !== 8'(base + k) || wr_data !== exp_char(int'(mvs[v]), k)) begin
            n_fail++;
            $display("FAIL conv_write v=%0d k=%0d: en=%b addr=%0d data=%h, want 1 %0d %h",
                     v, k, wr_en, wr_addr, wr_data, base + k, exp_char(int'(mvs[v]), k));
          end
          exp_ram[base + k] = exp_char(int'(mvs[v]), k);
        end else if (i < 12) begin
          n_checks++;
          if (wr_en !== 1'b0 || busy !== 1'b1 || vol_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL conv_busy v=%0d cyc=%0d: en=%b busy=%b ready=%b, want 0 1 0", v, i, wr_en, busy, vol_ready);
          end
        end else begin
          n_checks++;
          if (wr_en !== 1'b0 || vol_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL conv_done v=%0d: en=%b ready=%b busy=%b, want 0 1 0", v, wr_en, vol_ready, busy);
          end
        end
      end
      n_checks++;
      if (wr_count - wc0 !== 4) begin
        n_fail++;
        $display("FAIL conv_count v=%0d: writes=%0d, want 4", v, wr_count - wc0);
      end
    end
  endtask

  task automatic test_bad_channel();
    int wc0;
    wc0 = wr_count;
    offer(4'd14, 12'd1234, 1'b0);
    n_checks++;
    if (ch_err !== 1'b1 || vol_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_ch_pulse: ch_err=%b ready=%b busy=%b, want 1 1 0", ch_err, vol_ready, busy);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_ch_width: ch_err=%b one cycle later, want 0", ch_err);
    end
    offer(4'd15, 12'd7, 1'b0);
    n_checks++;
    if (ch_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_ch15: ch_err=%b, want 1", ch_err);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_count !== wc0 || vol_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_ch_nowrite: writes=%0d ready=%b, want 0 1", wr_count - wc0, vol_ready);
    end
  endtask

  task automatic test_back_to_back();
    int wc0;
    wc0 = wr_count;
    offer(4'd2, 12'd1000, 1'b1);
    vol_ch = 4'd3;
    vol_mv = 12'd2222;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i >= 12 && i <= 15) begin
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'(30 + i - 12) || wr_data !== exp_char(1000, i - 12)) begin
          n_fail++;
          $display("FAIL b2b_first k=%0d: en=%b addr=%0d data=%h, want 1 %0d %h",
                   i - 12, wr_en, wr_addr, wr_data, 30 + i - 12, exp_char(1000, i - 12));
        end
        exp_ram[30 + i - 12] = exp_char(1000, i - 12);
      end
    end
    n_checks++;
    if (vol_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: ready=%b before edge T+17, want 1", vol_ready);
    end
    @(posedge clk);
    @(negedge clk);
    vol_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || vol_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b ready=%b after T+17, want 1 0", busy, vol_ready);
    end
    for (int k = 0; k < 4; k++) exp_ram[42 + k] = exp_char(2222, k);
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_count - wc0 !== 8) begin
      n_fail++;
      $display("FAIL b2b_count: writes=%0d, want 8", wr_count - wc0);
    end
    for (int a = 30; a < 46; a++) begin
      n_checks++;
      if (ram[a] !== exp_ram[a]) begin
        n_fail++;
        $display("FAIL b2b_ram addr=%0d: got %h, want %h", a, ram[a], exp_ram[a]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int wc0;
    offer(4'd5, 12'd3300, 1'b0);
    wc0 = wr_count;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0 || vol_ready !== 1'b1 || busy !== 1'b0 || wr_addr !== 8'd0 || wr_data !== 7'h20) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: en=%b ready=%b busy=%b addr=%0d data=%h, want 0 1 0 0 20",
               wr_en, vol_ready, busy, wr_addr, wr_data);
    end
    rst = 1'b0;
    exp_ram[66] = 7'h33;
    exp_ram[67] = 7'h33;
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_count - wc0 !== 2) begin
      n_fail++;
      $display("FAIL rst_mid_count: writes=%0d, want 2", wr_count - wc0);
    end
    for (int a = 66; a < 70; a++) begin
      n_checks++;
      if (ram[a] !== exp_ram[a]) begin
        n_fail++;
        $display("FAIL rst_mid_ram addr=%0d: got %h, want %h", a, ram[a], exp_ram[a]);
      end
    end
  endtask

  task automatic test_sweep();
    int mv;
    for (int ch = 0; ch < 14; ch++) begin
      mv = int'($urandom_range(0, 4095));
      offer(4'(ch), 12'(mv), 1'b0);
      for (int k = 0; k < 4; k++) exp_ram[ch * 12 + 6 + k] = exp_char(mv, k);
    end
    repeat (25) @(negedge clk);
    for (int a = 0; a < 256; a++) begin
      n_checks++;
      if (ram[a] !== exp_ram[a]) begin
        n_fail++;
        $display("FAIL sweep_ram addr=%0d: got %h, want %h", a, ram[a], exp_ram[a]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      ram[a]     = init_char(a);
      exp_ram[a] = init_char(a);
    end
    test_reset();
    test_conversion();
    test_bad_channel();
    test_back_to_back();
    test_reset_mid_write();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
